// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared camera-path types and constants
package cam_pkg;

  localparam int H_ACTIVE_DEF = 800;
  localparam int V_ACTIVE_DEF = 480;
  localparam int COORD_W      = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } raster_state_t;

endpackage

// File: rtl/rgb2gray.sv
// rtl/rgb2gray.sv - registered R + 2G + B weighted sum
module rgb2gray #(
  parameter int IN_W = 10
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [IN_W-1:0] red_i,
  input  logic [IN_W-1:0] green_i,
  input  logic [IN_W-1:0] blue_i,
  output logic [IN_W+1:0] sum_o
);

  logic [IN_W+1:0] sum_d;
  logic [IN_W+1:0] sum_q;

  // IN_W+2 bits hold the worst case 4*(2^IN_W - 1) without overflow
  assign sum_d = (IN_W+2)'(red_i) + ((IN_W+2)'(green_i) << 1) + (IN_W+2)'(blue_i);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/gray_raster_source.sv
// rtl/gray_raster_source.sv - RGB to gray with raster coordinates and frame sequencing
module gray_raster_source
  import cam_pkg::*;
#(
  parameter int IN_W     = 10,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic                      iClk,
  input  logic                      iRst_N,
  input  logic [IN_W-1:0]           iRed,
  input  logic [IN_W-1:0]           iGreen,
  input  logic [IN_W-1:0]           iBlue,
  input  logic                      iValid,
  input  logic                      iFrameStart,
  output logic [7:0]                oGray,
  output logic                      oValid,
  output logic signed [COORD_W-1:0] oX_Cont,
  output logic signed [COORD_W-1:0] oY_Cont,
  output logic                      oFrameDone,
  output logic                      oShortFrame,
  output logic                      oOverrun
);

  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE);
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  raster_state_t state_q, state_d;
  logic [XW-1:0] x_q, x_d, pix_x;
  logic [YW-1:0] y_q, y_d, pix_y;
  logic          overrun_q, overrun_d;
  logic          pix_emit, pix_last, short_pulse;

  logic [IN_W+1:0] s1_sum;
  logic            s1_valid_q, s1_done_q, s1_short_q;
  logic [XW-1:0]   s1_x_q;
  logic [YW-1:0]   s1_y_q;

  logic [7:0]         gray_q;
  logic               valid_q, done_q, short_q;
  logic [COORD_W-1:0] xo_q, yo_q;
  logic               unused_sum_lsbs;

  rgb2gray #(.IN_W(IN_W)) u_rgb2gray (
    .clk_i  (iClk),
    .rst_ni (iRst_N),
    .red_i  (iRed),
    .green_i(iGreen),
    .blue_i (iBlue),
    .sum_o  (s1_sum)
  );

  // A frame start is applied before any pixel seen in the same cycle
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    overrun_d   = overrun_q;
    pix_x       = x_q;
    pix_y       = y_q;
    pix_emit    = 1'b0;
    pix_last    = 1'b0;
    short_pulse = 1'b0;
    if (iFrameStart) begin
      short_pulse = (state_q == ACTIVE) && ((x_q != '0) || (y_q != '0));
      state_d     = ACTIVE;
      x_d         = '0;
      y_d         = '0;
      pix_x       = '0;
      pix_y       = '0;
    end
    if (iValid) begin
      if (iFrameStart || (state_q == ACTIVE)) begin
        pix_emit = 1'b1;
        pix_last = (pix_x == X_LAST) && (pix_y == Y_LAST);
        if (pix_last) begin
          state_d = DONE;
          x_d     = '0;
          y_d     = '0;
        end else if (pix_x == X_LAST) begin
          x_d = '0;
          y_d = pix_y + YW'(1);
        end else begin
          x_d = pix_x + XW'(1);
        end
      end else if (state_q == DONE) begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst_N) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      overrun_q  <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_done_q  <= 1'b0;
      s1_short_q <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      gray_q     <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      short_q    <= 1'b0;
      xo_q       <= '0;
      yo_q       <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      overrun_q  <= overrun_d;
      s1_valid_q <= pix_emit;
      s1_done_q  <= pix_last;
      s1_short_q <= short_pulse;
      s1_x_q     <= pix_x;
      s1_y_q     <= pix_y;
      valid_q    <= s1_valid_q;
      done_q     <= s1_valid_q & s1_done_q;
      short_q    <= s1_short_q;
      // Pixel outputs hold their last value between valid pixels
      if (s1_valid_q) begin
        gray_q <= s1_sum[IN_W+1:IN_W-6];
        xo_q   <= COORD_W'(s1_x_q);
        yo_q   <= COORD_W'(s1_y_q);
      end
    end
  end

  assign unused_sum_lsbs = ^s1_sum[IN_W-7:0];

  assign oGray       = gray_q;
  assign oValid      = valid_q;
  assign oX_Cont     = xo_q;
  assign oY_Cont     = yo_q;
  assign oFrameDone  = done_q;
  assign oShortFrame = short_q;
  assign oOverrun    = overrun_q;

endmodule
